// File: rtl/pipe_arb_pkg.sv
// Shared defaults and helpers for the pipelined round-robin arbiter.
package pipe_arb_pkg;

  localparam int unsigned DEF_NREQ   = 4;
  localparam int unsigned DEF_DWIDTH = 32;

  // Increment with wrap at n, valid for any n (not just powers of two).
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Upstream (per-requester) and downstream handshake bundle for pipe_rr_arbiter.
interface pipe_rr_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 32
);
  localparam int unsigned SRCW = $clog2(NREQ);

  logic [NREQ-1:0]   i_valid;
  logic [DWIDTH-1:0] i_data [NREQ];
  logic [NREQ-1:0]   o_ready;
  logic [DWIDTH-1:0] o_data;
  logic [SRCW-1:0]   o_src;
  logic              o_valid;
  logic              i_ready;

  // slave: the arbiter; master: the producers/consumer around it
  modport slave  (input i_valid, i_data, i_ready, output o_ready, o_data, o_src, o_valid);
  modport master (output i_valid, i_data, i_ready, input o_ready, o_data, o_src, o_valid);
endinterface

// File: rtl/pipe_arb_rr_pick.sv
// Combinational rotate/priority scan: first set req bit at or after ptr, wrapping.
module pipe_arb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SRCW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic            pick_valid,
  output logic [SRCW-1:0] pick
);

  int unsigned idx;

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[SRCW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = SRCW'(idx);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready stage.
// Optional stall counter port o_stall_cnt is built when PIPE_ARB_PERF_EN is defined.
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned SRCW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_rr_arbiter_if.slave        bus
`ifdef PIPE_ARB_PERF_EN
  ,
  output logic [31:0]             o_stall_cnt
`endif
);

  logic              valid_q;
  logic [DWIDTH-1:0] data_q;
  logic [SRCW-1:0]   src_q;
  logic [SRCW-1:0]   ptr;
  logic              load;
  logic              pick_valid;
  logic [SRCW-1:0]   pick;

  pipe_arb_rr_pick #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_pick (
    .req        (bus.i_valid),
    .ptr        (ptr),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  assign load = (bus.i_ready || !valid_q) && !reset && !flush;

  // The pick is always a valid requester, so a grant is also a transfer.
  always_comb begin
    bus.o_ready = '0;
    if (load && pick_valid) bus.o_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      if (pick_valid) begin
        valid_q <= 1'b1;
        data_q  <= bus.i_data[pick];
        src_q   <= pick;
        ptr     <= SRCW'(rr_next(32'(pick), NREQ));
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_src   = src_q;

`ifdef PIPE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_stall_cnt <= '0;
    end else if (valid_q && !bus.i_ready && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed table-driven bench for pipe_rr_arbiter (NREQ=4, DWIDTH=32).
module tb_pipe_rr_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DWIDTH = 32;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  iv;
    logic        ir;
    logic [3:0]  ordy;
    logic        ov;
    logic        pay;
    logic [1:0]  src;
    logic [31:0] dat;
    int unsigned stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_rr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

  pipe_rr_arbiter #(
    .NREQ   (NREQ),
    .DWIDTH (DWIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus)
`ifdef PIPE_ARB_PERF_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

`ifndef PIPE_ARB_PERF_EN
  assign stall_cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic [3:0] iv, input logic ir,
                              input logic [3:0] ordy, input logic ov, input logic pay,
                              input logic [1:0] src, input logic [31:0] dat, input int unsigned stall);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ir = ir; v.ordy = ordy;
    v.ov = ov; v.pay = pay; v.src = src; v.dat = dat; v.stall = stall;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int waited;

    // Each row: drive inputs, then at negedge check o_ready (comb) and the held registers.
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 1, 0, 32'h00, 0)); // reset with all valid
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 1, 0, 32'h00, 0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 1, 0, 32'h00, 0)); // first grant -> 0
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 1, 0, 32'h10, 0)); // full contention
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h4, 1, 1, 1, 32'h11, 0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h8, 1, 1, 2, 32'h12, 0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 1, 1, 3, 32'h13, 0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h2, 1, 1, 0, 32'h10, 0)); // leaves ptr=2
    tbl.push_back(mk(0, 0, 4'hA, 1, 4'h8, 1, 1, 1, 32'h11, 0)); // sparse 1,3 from ptr=2
    tbl.push_back(mk(0, 0, 4'hA, 1, 4'h2, 1, 1, 3, 32'h13, 0));
    tbl.push_back(mk(0, 0, 4'hA, 1, 4'h8, 1, 1, 1, 32'h11, 0));
    tbl.push_back(mk(0, 0, 4'hA, 1, 4'h2, 1, 1, 3, 32'h13, 0));
    tbl.push_back(mk(0, 0, 4'h4, 1, 4'h4, 1, 1, 1, 32'h11, 0)); // load src=2, ptr->3
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 2, 32'h12, 0)); // 5 stall cycles
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 2, 32'h12, 1));
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 2, 32'h12, 2));
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 2, 32'h12, 3));
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 2, 32'h12, 4));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h8, 1, 1, 2, 32'h12, 5)); // resume -> grant 3
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 3, 32'h13, 5)); // stall then flush
    tbl.push_back(mk(0, 1, 4'hF, 0, 4'h0, 1, 1, 3, 32'h13, 6));
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h1, 0, 0, 0, 32'h00, 7)); // ptr kept at 0
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 1, 1, 0, 32'h10, 7)); // 4 idle cycles
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 0, 1, 0, 32'h10, 7));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 0, 1, 0, 32'h10, 7));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 0, 1, 0, 32'h10, 7));
    tbl.push_back(mk(0, 0, 4'h4, 1, 4'h4, 0, 1, 0, 32'h10, 7)); // lone requester 2
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 1, 1, 2, 32'h12, 7));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h0, 0, 1, 2, 32'h12, 7));
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h8, 0, 1, 2, 32'h12, 7)); // empty reg loads despite !i_ready
    tbl.push_back(mk(0, 0, 4'hF, 0, 4'h0, 1, 1, 3, 32'h13, 7));
    tbl.push_back(mk(1, 1, 4'hF, 0, 4'h0, 1, 1, 3, 32'h13, 8)); // reset+flush mid-stall
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h1, 0, 1, 0, 32'h00, 0));

    for (int k = 0; k < int'(NREQ); k++) bus.i_data[k] = 32'(k) + 32'h10;
    reset = 1'b1;
    flush = 1'b0;
    bus.i_valid = 4'hF;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < tbl.size(); r++) begin
      reset       = tbl[r].rst;
      flush       = tbl[r].fl;
      bus.i_valid = tbl[r].iv;
      bus.i_ready = tbl[r].ir;
      @(negedge clk);
      chk("o_ready", r, 64'(bus.o_ready), 64'(tbl[r].ordy));
      chk("o_valid", r, 64'(bus.o_valid), 64'(tbl[r].ov));
      if (tbl[r].pay) begin
        chk("o_src", r, 64'(bus.o_src), 64'(tbl[r].src));
        chk("o_data", r, 64'(bus.o_data), 64'(tbl[r].dat));
      end
`ifdef PIPE_ARB_PERF_EN
      chk("o_stall_cnt", r, 64'(stall_cnt), 64'(tbl[r].stall));
`endif
      @(posedge clk); #1;
    end

    // Fairness: from ptr=1 with everyone valid, requester 2 is granted on the second cycle.
    reset = 1'b0;
    flush = 1'b0;
    bus.i_valid = 4'hF;
    bus.i_ready = 1'b1;
    waited = 0;
    for (int c = 1; c <= 2 * int'(NREQ); c++) begin
      @(negedge clk);
      if (bus.o_ready[2]) begin
        waited = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("fair_wait", 100, 64'(waited), 64'd2);
    @(posedge clk); #1;
    chk("fair_src", 101, 64'(bus.o_src), 64'd2);
    chk("fair_data", 101, 64'(bus.o_data), 64'h12);
    chk("fair_next", 101, 64'(bus.o_ready), 64'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
